// File: rtl/ccff_chain_loader_if.sv
// Word-stream handshake feeding the CCFF chain loader.
// The host drives in_data/in_valid (master); the loader returns in_ready (slave).
interface ccff_chain_loader_if #(
    parameter int WORD_W = 32
) ();
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/ccff_chain_loader.sv
// Streams a configuration bitstream LSB-first into the tile CCFF chain on prog_clk.
// Readback verify pass (VERIFY state, comparator, mismatch counters) is built only with CCFF_LOADER_READBACK_EN.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 32
) (
    input  logic                           prog_clk,
    input  logic                           prog_reset,
    input  logic                           start_load,
    input  logic                           start_verify,
    ccff_chain_loader_if.slave             in_if,
    output logic                           ccff_head,
    output logic                           ccff_shift_en,
    input  logic                           ccff_tail,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(CHAIN_LEN+1)-1:0] bit_count,
    output logic                           verify_err,
    output logic [15:0]                    mismatch_cnt
);
    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int RW = $clog2(WORD_W + 1);

`ifdef CCFF_LOADER_READBACK_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_VERIFY = 2'd2,
        S_DONE   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd3
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   buf_q, buf_d;
    logic [RW-1:0]       rem_q, rem_d;
    logic [CW-1:0]       bit_count_q, bit_count_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                shift_en_q, shift_en_d;
    logic                mis_q, mis_d;
    logic                fin_q, fin_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                last_s;
    logic                in_ready_s;
    logic                accept_s;
    logic                verify_s;
    logic                verify_next_s;

`ifdef CCFF_LOADER_READBACK_EN
    assign verify_s      = (state_q == S_VERIFY);
    assign verify_next_s = (state_d == S_VERIFY);
`else
    logic start_verify_unused_s;
    assign start_verify_unused_s = start_verify;
    assign verify_s      = 1'b0;
    assign verify_next_s = 1'b0;
`endif

    // The final shift of a pass must not also swallow a new word.
    assign last_s     = (bit_count_q == CW'(CHAIN_LEN - 1));
    assign in_ready_s = busy_q && ((rem_q == {RW{1'b0}}) ||
                                   ((rem_q == RW'(1)) && shift_en_q && !last_s));
    assign accept_s   = in_if.in_valid && in_ready_s;

    // Next-state, buffer, counters and readback bookkeeping
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        rem_d       = rem_q;
        bit_count_d = bit_count_q;
        done_d      = done_q;
        fin_d       = 1'b0;
        mis_d       = 1'b0;
        cnt_d       = cnt_q;
        err_d       = err_q;

        // Compare result from the previous shift edge lands one cycle later
        if (mis_q) begin
            err_d = 1'b1;
            if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            err_d = err_q;
        end

        if (fin_q) begin
            done_d = 1'b1;
        end else begin
            done_d = done_q;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_load) begin
                    state_d     = S_LOAD;
                    bit_count_d = {CW{1'b0}};
                    done_d      = 1'b0;
                end
`ifdef CCFF_LOADER_READBACK_EN
                else if (start_verify) begin
                    state_d     = S_VERIFY;
                    bit_count_d = {CW{1'b0}};
                    done_d      = 1'b0;
                    cnt_d       = 16'd0;
                    err_d       = 1'b0;
                end
`endif
                else begin
                    state_d = state_q;
                end
            end
`ifdef CCFF_LOADER_READBACK_EN
            S_LOAD, S_VERIFY: begin
`else
            S_LOAD: begin
`endif
                if (shift_en_q) begin
                    buf_d       = buf_q >> 1;
                    rem_d       = rem_q - RW'(1);
                    bit_count_d = bit_count_q + CW'(1);
                    mis_d       = verify_s && (ccff_tail != buf_q[0]);
                    if (last_s) begin
                        state_d = S_DONE;
                        rem_d   = {RW{1'b0}};
                        if (verify_s) begin
                            fin_d = 1'b1;
                        end else begin
                            done_d = 1'b1;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    buf_d = buf_q;
                end
                if (accept_s) begin
                    buf_d = in_if.in_data;
                    rem_d = RW'(WORD_W);
                end else begin
                    rem_d = rem_d;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d     = (state_d == S_LOAD) || verify_next_s;
        shift_en_d = busy_d && (rem_d != {RW{1'b0}});
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q     <= S_IDLE;
            buf_q       <= {WORD_W{1'b0}};
            rem_q       <= {RW{1'b0}};
            bit_count_q <= {CW{1'b0}};
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            shift_en_q  <= 1'b0;
            mis_q       <= 1'b0;
            fin_q       <= 1'b0;
            cnt_q       <= 16'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            rem_q       <= rem_d;
            bit_count_q <= bit_count_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            shift_en_q  <= shift_en_d;
            mis_q       <= mis_d;
            fin_q       <= fin_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    assign in_if.in_ready = in_ready_s;
    assign ccff_head      = buf_q[0];
    assign ccff_shift_en  = shift_en_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign bit_count      = bit_count_q;
    assign verify_err     = err_q;
    assign mismatch_cnt   = cnt_q;
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: 40-bit chain model, 16-bit words.
// Verify-pass tests run when CCFF_LOADER_READBACK_EN is defined; otherwise the compiled-out check runs.
module tb_ccff_chain_loader;
    localparam int CL = 40;
    localparam int WW = 16;
    localparam int CW = $clog2(CL + 1);
    localparam logic [CL-1:0] GOLD = 40'hFF_0F0F_A5C3;
    localparam logic [CL-1:0] BAD  = 40'hFF_0F0E_A5C3;

    logic          prog_clk = 1'b0;
    logic          prog_reset;
    logic          start_load;
    logic          start_verify;
    logic          ccff_head;
    logic          ccff_shift_en;
    logic          ccff_tail;
    logic          busy;
    logic          done;
    logic [CW-1:0] bit_count;
    logic          verify_err;
    logic [15:0]   mismatch_cnt;

    logic [CL-1:0] chain = '0;
    int            shift_cnt = 0;
    int            stall_cnt = 0;
    int            checks_cnt = 0;
    int            errors_cnt = 0;
    int            s0;
    int            st0;

    ccff_chain_loader_if #(.WORD_W(WW)) in_if ();

    ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .prog_clk      (prog_clk),
        .prog_reset    (prog_reset),
        .start_load    (start_load),
        .start_verify  (start_verify),
        .in_if         (in_if),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .done          (done),
        .bit_count     (bit_count),
        .verify_err    (verify_err),
        .mismatch_cnt  (mismatch_cnt)
    );

    always #5 prog_clk = ~prog_clk;

    // Chain model: new bit enters at the top, tail is bit 0
    assign ccff_tail = chain[0];
    always @(posedge prog_clk) begin
        if (ccff_shift_en) begin
            chain     <= {ccff_head, chain[CL-1:1]};
            shift_cnt <= shift_cnt + 1;
        end
        if (busy && !ccff_shift_en) stall_cnt <= stall_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; holds valid low for `gap` ready cycles, then hands over one word.
    task automatic push(input logic [WW-1:0] w, input int gap);
        int g = 0;
        int t = 0;
        in_if.in_valid = 1'b0;
        while (g < gap && t < 200) begin
            if (in_if.in_ready) g++;
            @(negedge prog_clk);
            t++;
        end
        in_if.in_valid = 1'b1;
        in_if.in_data  = w;
        while (!in_if.in_ready && t < 200) begin
            @(negedge prog_clk);
            t++;
        end
        check_eq("push_tmo", (t < 200), 1);
        @(negedge prog_clk);
        in_if.in_valid = 1'b0;
    endtask

    task automatic start_pass(input bit vfy);
        s0  = shift_cnt;
        st0 = stall_cnt;
        if (vfy) start_verify = 1'b1;
        else     start_load   = 1'b1;
        @(negedge prog_clk);
        start_load   = 1'b0;
        start_verify = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 200) begin
            @(negedge prog_clk);
            t++;
        end
        check_eq("done_tmo", done, 1);
    endtask

    task automatic run_pass(input bit vfy, input logic [WW-1:0] w2, input int gap);
        start_pass(vfy);
        push(16'hA5C3, 0);
        push(w2, gap);
        push(16'h00FF, gap);
        check_eq("ready_after_w3", in_if.in_ready, 0);
        wait_done();
    endtask

    initial begin
        prog_reset     = 1'b1;
        start_load     = 1'b0;
        start_verify   = 1'b0;
        in_if.in_valid = 1'b0;
        in_if.in_data  = '0;
        repeat (2) @(negedge prog_clk);
        prog_reset = 1'b0;
        @(negedge prog_clk);
        check_eq("rst_busy",  busy, 0);
        check_eq("rst_done",  done, 0);
        check_eq("rst_shift", ccff_shift_en, 0);
        check_eq("rst_head",  ccff_head, 0);
        check_eq("rst_bc",    bit_count, 0);
        check_eq("rst_ready", in_if.in_ready, 0);
        check_eq("rst_err",   verify_err, 0);
        check_eq("rst_mcnt",  mismatch_cnt, 0);

        // 1: basic load, streaming
        run_pass(1'b0, 16'h0F0F, 0);
        check_eq("t1_shifts", shift_cnt - s0, 40);
        check_eq("t1_stalls", stall_cnt - st0, 1);
        check_eq("t1_chain",  chain, GOLD);
        check_eq("t1_bc",     bit_count, 40);
        check_eq("t1_busy",   busy, 0);
        check_eq("t1_ready",  in_if.in_ready, 0);

        // 2: five-cycle stalls before words 2 and 3
        chain = '0;
        run_pass(1'b0, 16'h0F0F, 5);
        check_eq("t2_shifts", shift_cnt - s0, 40);
        check_eq("t2_stalls", stall_cnt - st0, 11);
        check_eq("t2_chain",  chain, GOLD);
        check_eq("t2_bc",     bit_count, 40);

`ifdef CCFF_LOADER_READBACK_EN
        // 3: clean verify
        run_pass(1'b1, 16'h0F0F, 0);
        check_eq("t3_err",   verify_err, 0);
        check_eq("t3_mcnt",  mismatch_cnt, 0);
        check_eq("t3_chain", chain, GOLD);
        check_eq("t3_bc",    bit_count, 40);

        // 4: verify with one flipped bit in word 2
        run_pass(1'b1, 16'h0F0E, 0);
        check_eq("t4_err",   verify_err, 1);
        check_eq("t4_mcnt",  mismatch_cnt, 1);
        check_eq("t4_chain", chain, BAD);
`endif

        // 5a: reset after 17 shifts
        start_pass(1'b0);
        push(16'hA5C3, 0);
        push(16'h0F0F, 0);
        @(negedge prog_clk);
        check_eq("t5_bc17", bit_count, 17);
        prog_reset = 1'b1;
        @(negedge prog_clk);
        check_eq("t5_busy",  busy, 0);
        check_eq("t5_shift", ccff_shift_en, 0);
        check_eq("t5_bc",    bit_count, 0);
        check_eq("t5_err",   verify_err, 0);
        check_eq("t5_mcnt",  mismatch_cnt, 0);
        prog_reset = 1'b0;
        @(negedge prog_clk);

        // 5b: start_load during a pass is ignored
        start_pass(1'b0);
        push(16'hA5C3, 0);
        repeat (5) @(negedge prog_clk);
        check_eq("t5_bc5", bit_count, 5);
        start_load = 1'b1;
        @(negedge prog_clk);
        start_load = 1'b0;
        check_eq("t5_bc6",   bit_count, 6);
        check_eq("t5_busy2", busy, 1);
        push(16'h0F0F, 0);
        push(16'h00FF, 0);
        wait_done();
        check_eq("t5_bc40", bit_count, 40);
        check_eq("t5_chain", chain, GOLD);

`ifndef CCFF_LOADER_READBACK_EN
        // 6: start_verify has no effect without readback
        prog_reset = 1'b1;
        @(negedge prog_clk);
        prog_reset = 1'b0;
        start_pass(1'b1);
        @(negedge prog_clk);
        check_eq("t6_busy",  busy, 0);
        check_eq("t6_shift", ccff_shift_en, 0);
        check_eq("t6_done",  done, 0);
        check_eq("t6_err",   verify_err, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
